// File: rtl/spi_slave_sync_if.sv
// spi_slave_sync transmit/receive word handshake bundle.
// The slave modport is the SPI slave's view; master is the decoder's.
interface spi_slave_sync_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );
endinterface

// File: rtl/spi_slave_sync.sv
// Oversampled SPI slave: SCK/CS/MOSI synchronised into clk,
// any CPOL/CPHA, valid/ready tx holding register, word rx pulses.
module spi_slave_sync #(
  parameter int WIDTH       = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_clk,
  input  logic spi_cs,
  input  logic spi_mosi,
  output logic spi_miso,
  output logic spi_miso_oe,
  output logic transm_start,
  output logic transm_end,
  output logic tx_underrun,
  spi_slave_sync_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sck_d;
  logic cs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= CPOL;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  logic sck_s;
  logic cs_s;
  logic mosi_s;
  logic lead_e;
  logic trail_e;
  logic sample_e;
  logic shift_e;
  logic cs_fall;
  logic cs_rise;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign lead_e   = (sck_d == CPOL) && (sck_s != CPOL);
  assign trail_e  = (sck_d != CPOL) && (sck_s == CPOL);
  assign sample_e = CPHA ? trail_e : lead_e;
  assign shift_e  = CPHA ? lead_e : trail_e;
  assign cs_fall  = cs_d && !cs_s;
  assign cs_rise  = !cs_d && cs_s;

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic             rx_pend;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] hold_q;
  logic             tx_ready_q;

  logic             load_now;
  logic             capture;
  logic [WIDTH-1:0] load_word;

  // bit_cnt sits at LAST both before a word's first bit and right
  // after its final sample, so one compare marks every word boundary.
  always_comb begin
    load_now = 1'b0;
    unique case (state)
      IDLE:    load_now = cs_fall && (CPHA == 1'b0);
      ACTIVE:  load_now = !cs_rise && shift_e && (bit_cnt == LAST);
      default: load_now = 1'b0;
    endcase
    capture   = bus.tx_valid && tx_ready_q;
    load_word = tx_ready_q ? '0 : hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= LAST;
      rx_shift     <= '0;
      rx_pend      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_shift     <= '0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      transm_start <= 1'b0;
      transm_end   <= 1'b0;
    end else begin
      transm_start <= 1'b0;
      transm_end   <= 1'b0;
      rx_pend      <= 1'b0;
      rx_valid_q   <= rx_pend;
      if (rx_pend) begin
        rx_data_q <= rx_shift;
      end
      if (load_now) begin
        tx_shift <= load_word;
        spi_miso <= load_word[WIDTH-1];
      end
      unique case (state)
        IDLE: begin
          if (cs_fall) begin
            state        <= ACTIVE;
            transm_start <= 1'b1;
            spi_miso_oe  <= 1'b1;
            bit_cnt      <= LAST;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            transm_end  <= 1'b1;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            bit_cnt     <= LAST;
          end else begin
            if (sample_e) begin
              rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};
              if (bit_cnt == '0) begin
                rx_pend <= 1'b1;
                bit_cnt <= LAST;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end
            if (shift_e && !load_now) begin
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
              spi_miso <= tx_shift[WIDTH-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A load and a capture in one cycle: load sees the old content,
  // the capture refills the register and tx_ready stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      tx_ready_q  <= 1'b1;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= load_now && tx_ready_q;
      if (capture) begin
        hold_q     <= bus.tx_data;
        tx_ready_q <= 1'b0;
      end else if (load_now && !tx_ready_q) begin
        tx_ready_q <= 1'b1;
      end
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: mode 0 (8b), mode 1 (8b)
// and mode 3 (16b) instances driven by one bit-banged SPI master.
module tb_spi_slave_sync;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck_raw = 1'b0;
  logic mosi = 1'b0;
  logic cs0 = 1'b1;
  logic cs1 = 1'b1;
  logic cs2 = 1'b1;
  logic sck0;
  logic sck2;
  logic miso0, miso1, miso2;
  logic oe0, oe1, oe2;
  logic st0, st1, st2;
  logic en0, en1, en2;
  logic ur0, ur1, ur2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign sck0 = sck_raw;
  assign sck2 = ~sck_raw;

  spi_slave_sync_if #(.WIDTH(8))  if0 ();
  spi_slave_sync_if #(.WIDTH(8))  if1 ();
  spi_slave_sync_if #(.WIDTH(16)) if2 ();

  spi_slave_sync #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .spi_clk(sck0), .spi_cs(cs0),
    .spi_mosi(mosi), .spi_miso(miso0), .spi_miso_oe(oe0),
    .transm_start(st0), .transm_end(en0), .tx_underrun(ur0),
    .bus(if0)
  );

  spi_slave_sync #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .spi_clk(sck0), .spi_cs(cs1),
    .spi_mosi(mosi), .spi_miso(miso1), .spi_miso_oe(oe1),
    .transm_start(st1), .transm_end(en1), .tx_underrun(ur1),
    .bus(if1)
  );

  spi_slave_sync #(.WIDTH(16), .CPOL(1'b1), .CPHA(1'b1)) u2 (
    .clk(clk), .rst_n(rst_n), .spi_clk(sck2), .spi_cs(cs2),
    .spi_mosi(mosi), .spi_miso(miso2), .spi_miso_oe(oe2),
    .transm_start(st2), .transm_end(en2), .tx_underrun(ur2),
    .bus(if2)
  );

  int n_rx[3];
  int n_st[3];
  int n_en[3];
  int n_ur[3];
  logic [31:0] last_rx[3];
  logic [31:0] prev_rx[3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      n_rx[k] = 0; n_st[k] = 0; n_en[k] = 0; n_ur[k] = 0;
      last_rx[k] = '0; prev_rx[k] = '0;
    end
  end

  always @(negedge clk) begin
    if (if0.rx_valid) begin
      n_rx[0]++; prev_rx[0] = last_rx[0]; last_rx[0] = 32'(if0.rx_data);
    end
    if (if1.rx_valid) begin
      n_rx[1]++; prev_rx[1] = last_rx[1]; last_rx[1] = 32'(if1.rx_data);
    end
    if (if2.rx_valid) begin
      n_rx[2]++; prev_rx[2] = last_rx[2]; last_rx[2] = 32'(if2.rx_data);
    end
    if (st0) n_st[0]++;
    if (st1) n_st[1]++;
    if (st2) n_st[2]++;
    if (en0) n_en[0]++;
    if (en1) n_en[1]++;
    if (en2) n_en[2]++;
    if (ur0) n_ur[0]++;
    if (ur1) n_ur[1]++;
    if (ur2) n_ur[2]++;
  end

  logic [31:0] mi;
  logic [31:0] mi_b;
  int s_rx, s_st, s_en, s_ur;
  logic ok_hs;

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cs_drive(input int d, input logic v);
    case (d)
      0:       cs0 = v;
      1:       cs1 = v;
      default: cs2 = v;
    endcase
  endtask

  function automatic logic miso_of(input int d);
    case (d)
      0:       return miso0;
      1:       return miso1;
      default: return miso2;
    endcase
  endfunction

  task automatic push_tx(input int d, input logic [31:0] data);
    case (d)
      0: begin if0.tx_data = data[7:0]; if0.tx_valid = 1'b1; end
      1: begin if1.tx_data = data[7:0]; if1.tx_valid = 1'b1; end
      default: begin if2.tx_data = data[15:0]; if2.tx_valid = 1'b1; end
    endcase
    wait_clk(1);
    if0.tx_valid = 1'b0;
    if1.tx_valid = 1'b0;
    if2.tx_valid = 1'b0;
  endtask

  task automatic snap(input int d);
    s_rx = n_rx[d]; s_st = n_st[d]; s_en = n_en[d]; s_ur = n_ur[d];
  endtask

  task automatic begin_x(input int d);
    cs_drive(d, 1'b0);
    wait_clk(HALF);
  endtask

  task automatic end_x(input int d);
    wait_clk(HALF);
    cs_drive(d, 1'b1);
    wait_clk(HALF);
  endtask

  // d=0 is CPHA=0 (data before the leading edge); others are CPHA=1.
  task automatic spi_word(input int d, input int w, input logic [31:0] mo,
                          input int nb, output logic [31:0] mo_in);
    mo_in = '0;
    for (int k = 0; k < nb; k++) begin
      int i;
      i = w - 1 - k;
      if (d == 0) begin
        mosi = mo[i];
        wait_clk(HALF);
        mo_in[i] = miso_of(d);
        sck_raw = 1'b1;
        wait_clk(HALF);
        sck_raw = 1'b0;
      end else begin
        sck_raw = 1'b1;
        mosi = mo[i];
        wait_clk(HALF);
        mo_in[i] = miso_of(d);
        sck_raw = 1'b0;
        wait_clk(HALF);
      end
    end
  endtask

  task automatic test_reset;
    logic [6:0] v;
    wait_clk(3);
    v = {miso0, oe0, if0.tx_ready, if0.rx_valid, st0, en0, ur0};
    n_cmp++;
    if (v !== 7'b0010000) begin
      n_bad++; $display("FAIL rst_outs_m0: got %b want 0010000", v);
    end
    n_cmp++;
    if (if0.rx_data !== 8'h00) begin
      n_bad++; $display("FAIL rst_rxdata_m0: got %h want 00", if0.rx_data);
    end
    v = {miso1, oe1, if1.tx_ready, if1.rx_valid, st1, en1, ur1};
    n_cmp++;
    if (v !== 7'b0010000) begin
      n_bad++; $display("FAIL rst_outs_m1: got %b want 0010000", v);
    end
    n_cmp++;
    if (if1.rx_data !== 8'h00) begin
      n_bad++; $display("FAIL rst_rxdata_m1: got %h want 00", if1.rx_data);
    end
    v = {miso2, oe2, if2.tx_ready, if2.rx_valid, st2, en2, ur2};
    n_cmp++;
    if (v !== 7'b0010000) begin
      n_bad++; $display("FAIL rst_outs_m3: got %b want 0010000", v);
    end
    n_cmp++;
    if (if2.rx_data !== 16'h0000) begin
      n_bad++; $display("FAIL rst_rxdata_m3: got %h want 0000", if2.rx_data);
    end
    rst_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic test_mode0;
    push_tx(0, 32'hA5);
    n_cmp++;
    if (if0.tx_ready !== 1'b0) begin
      n_bad++; $display("FAIL m0_ready_drop: got %b want 0", if0.tx_ready);
    end
    snap(0);
    begin_x(0);
    n_cmp++;
    if (oe0 !== 1'b1) begin
      n_bad++; $display("FAIL m0_oe_on: got %b want 1", oe0);
    end
    spi_word(0, 8, 32'h3C, 8, mi);
    end_x(0);
    n_cmp++;
    if (mi[7:0] !== 8'hA5) begin
      n_bad++; $display("FAIL m0_miso: got %h want a5", mi[7:0]);
    end
    n_cmp++;
    if (n_rx[0] - s_rx !== 1) begin
      n_bad++; $display("FAIL m0_rxv_cnt: got %0d want 1", n_rx[0] - s_rx);
    end
    n_cmp++;
    if (last_rx[0][7:0] !== 8'h3C) begin
      n_bad++; $display("FAIL m0_rxdata: got %h want 3c", last_rx[0][7:0]);
    end
    n_cmp++;
    if (n_st[0] - s_st !== 1) begin
      n_bad++; $display("FAIL m0_start: got %0d want 1", n_st[0] - s_st);
    end
    n_cmp++;
    if (n_en[0] - s_en !== 1) begin
      n_bad++; $display("FAIL m0_end: got %0d want 1", n_en[0] - s_en);
    end
    n_cmp++;
    if ({oe0, miso0} !== 2'b00) begin
      n_bad++; $display("FAIL m0_oe_off: got %b want 00", {oe0, miso0});
    end
  endtask

  task automatic test_back_to_back;
    push_tx(2, 32'h0F0F);
    snap(2);
    begin_x(2);
    ok_hs = 1'b0;
    fork
      spi_word(2, 16, 32'h1234, 16, mi);
      begin
        for (int k = 0; k < 200; k++) begin
          if (if2.tx_ready) begin
            ok_hs = 1'b1;
            break;
          end
          wait_clk(1);
        end
        if2.tx_data = 16'hF0F0;
        if2.tx_valid = 1'b1;
        wait_clk(1);
        if2.tx_valid = 1'b0;
      end
    join
    n_cmp++;
    if (ok_hs !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready_load1: got %b want 1", ok_hs);
    end
    spi_word(2, 16, 32'hBEEF, 16, mi_b);
    n_cmp++;
    if (if2.tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL b2b_ready_load2: got %b want 1", if2.tx_ready);
    end
    end_x(2);
    n_cmp++;
    if (mi[15:0] !== 16'h0F0F) begin
      n_bad++; $display("FAIL b2b_miso1: got %h want 0f0f", mi[15:0]);
    end
    n_cmp++;
    if (mi_b[15:0] !== 16'hF0F0) begin
      n_bad++; $display("FAIL b2b_miso2: got %h want f0f0", mi_b[15:0]);
    end
    n_cmp++;
    if (n_rx[2] - s_rx !== 2) begin
      n_bad++; $display("FAIL b2b_rxv_cnt: got %0d want 2", n_rx[2] - s_rx);
    end
    n_cmp++;
    if (prev_rx[2][15:0] !== 16'h1234) begin
      n_bad++; $display("FAIL b2b_rx1: got %h want 1234", prev_rx[2][15:0]);
    end
    n_cmp++;
    if (last_rx[2][15:0] !== 16'hBEEF) begin
      n_bad++; $display("FAIL b2b_rx2: got %h want beef", last_rx[2][15:0]);
    end
    n_cmp++;
    if (n_ur[2] - s_ur !== 0) begin
      n_bad++; $display("FAIL b2b_underrun: got %0d want 0", n_ur[2] - s_ur);
    end
  endtask

  task automatic test_underrun;
    n_cmp++;
    if (if1.tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL ur_empty: got %b want 1", if1.tx_ready);
    end
    snap(1);
    begin_x(1);
    spi_word(1, 8, 32'hFF, 8, mi);
    end_x(1);
    n_cmp++;
    if (mi[7:0] !== 8'h00) begin
      n_bad++; $display("FAIL ur_miso: got %h want 00", mi[7:0]);
    end
    n_cmp++;
    if (n_ur[1] - s_ur !== 1) begin
      n_bad++; $display("FAIL ur_pulse: got %0d want 1", n_ur[1] - s_ur);
    end
    n_cmp++;
    if (n_rx[1] - s_rx !== 1) begin
      n_bad++; $display("FAIL ur_rxv_cnt: got %0d want 1", n_rx[1] - s_rx);
    end
    n_cmp++;
    if (last_rx[1][7:0] !== 8'hFF) begin
      n_bad++; $display("FAIL ur_rxdata: got %h want ff", last_rx[1][7:0]);
    end
  endtask

  task automatic test_partial;
    snap(0);
    begin_x(0);
    spi_word(0, 8, 32'hAA, 5, mi);
    end_x(0);
    n_cmp++;
    if (n_rx[0] - s_rx !== 0) begin
      n_bad++; $display("FAIL part_no_rxv: got %0d want 0", n_rx[0] - s_rx);
    end
    n_cmp++;
    if (n_en[0] - s_en !== 1) begin
      n_bad++; $display("FAIL part_end: got %0d want 1", n_en[0] - s_en);
    end
    push_tx(0, 32'hC3);
    snap(0);
    begin_x(0);
    spi_word(0, 8, 32'h96, 8, mi);
    end_x(0);
    n_cmp++;
    if (mi[7:0] !== 8'hC3) begin
      n_bad++; $display("FAIL part_next_miso: got %h want c3", mi[7:0]);
    end
    n_cmp++;
    if (n_rx[0] - s_rx !== 1) begin
      n_bad++; $display("FAIL part_next_cnt: got %0d want 1", n_rx[0] - s_rx);
    end
    n_cmp++;
    if (last_rx[0][7:0] !== 8'h96) begin
      n_bad++; $display("FAIL part_next_rx: got %h want 96", last_rx[0][7:0]);
    end
  endtask

  task automatic test_reset_mid;
    logic [6:0] v;
    push_tx(0, 32'h5A);
    begin_x(0);
    spi_word(0, 8, 32'hFF, 4, mi);
    rst_n = 1'b0;
    #1;
    v = {miso0, oe0, if0.tx_ready, if0.rx_valid, st0, en0, ur0};
    n_cmp++;
    if (v !== 7'b0010000) begin
      n_bad++; $display("FAIL rstmid_outs: got %b want 0010000", v);
    end
    n_cmp++;
    if (if0.rx_data !== 8'h00) begin
      n_bad++; $display("FAIL rstmid_rxdata: got %h want 00", if0.rx_data);
    end
    cs0 = 1'b1;
    sck_raw = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(HALF);
    push_tx(0, 32'h42);
    snap(0);
    begin_x(0);
    spi_word(0, 8, 32'h81, 8, mi);
    end_x(0);
    n_cmp++;
    if (last_rx[0][7:0] !== 8'h81) begin
      n_bad++; $display("FAIL rstmid_rx: got %h want 81", last_rx[0][7:0]);
    end
    n_cmp++;
    if (n_rx[0] - s_rx !== 1) begin
      n_bad++; $display("FAIL rstmid_cnt: got %0d want 1", n_rx[0] - s_rx);
    end
    n_cmp++;
    if (mi[7:0] !== 8'h42) begin
      n_bad++; $display("FAIL rstmid_miso: got %h want 42", mi[7:0]);
    end
  endtask

  // tx_valid reaches the DUT on exactly the clock edge that performs
  // the first word's load (leading edge + two sync stages + detect).
  task automatic test_collision;
    push_tx(1, 32'h11);
    snap(1);
    begin_x(1);
    ok_hs = 1'b0;
    fork
      begin
        spi_word(1, 8, 32'h5A, 8, mi);
        spi_word(1, 8, 32'hC3, 8, mi_b);
      end
      begin
        wait_clk(2);
        if1.tx_data = 8'h22;
        if1.tx_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
          if (if1.tx_ready) begin
            ok_hs = 1'b1;
            wait_clk(1);
            break;
          end
          wait_clk(1);
        end
        if1.tx_valid = 1'b0;
      end
    join
    end_x(1);
    n_cmp++;
    if (ok_hs !== 1'b1) begin
      n_bad++; $display("FAIL col_accept: got %b want 1", ok_hs);
    end
    n_cmp++;
    if (mi[7:0] !== 8'h11) begin
      n_bad++; $display("FAIL col_word1: got %h want 11", mi[7:0]);
    end
    n_cmp++;
    if (mi_b[7:0] !== 8'h22) begin
      n_bad++; $display("FAIL col_word2: got %h want 22", mi_b[7:0]);
    end
    n_cmp++;
    if (n_ur[1] - s_ur !== 0) begin
      n_bad++; $display("FAIL col_underrun: got %0d want 0", n_ur[1] - s_ur);
    end
    n_cmp++;
    if (n_rx[1] - s_rx !== 2) begin
      n_bad++; $display("FAIL col_rxv_cnt: got %0d want 2", n_rx[1] - s_rx);
    end
    n_cmp++;
    if ({prev_rx[1][7:0], last_rx[1][7:0]} !== 16'h5AC3) begin
      n_bad++;
      $display("FAIL col_rx: got %h%h want 5ac3",
               prev_rx[1][7:0], last_rx[1][7:0]);
    end
  endtask

  initial begin
    if0.tx_data = '0; if0.tx_valid = 1'b0;
    if1.tx_data = '0; if1.tx_valid = 1'b0;
    if2.tx_data = '0; if2.tx_valid = 1'b0;
    test_reset();
    test_mode0();
    test_back_to_back();
    test_underrun();
    test_partial();
    test_reset_mid();
    test_collision();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
